// File: rtl/ray_dir_gen.sv
// ray_dir_gen: streams one ray direction per screen column from a latched player pose.
// Define RAY_DIR_ROUND_EN to round the plane*cameraX products half up instead of truncating.
module ray_dir_gen #(
    parameter int SCREEN_WIDTH = 320
) (
    input  logic                            pixel_clk_in,
    input  logic                            rst_in,
    input  logic [15:0]                     posX,
    input  logic [15:0]                     posY,
    input  logic [15:0]                     dirX,
    input  logic [15:0]                     dirY,
    input  logic [15:0]                     planeX,
    input  logic [15:0]                     planeY,
    input  logic                            valid_in,
    input  logic                            ready_in,
    output logic [15:0]                     rayDirX,
    output logic [15:0]                     rayDirY,
    output logic [15:0]                     posX_out,
    output logic [15:0]                     posY_out,
    output logic [$clog2(SCREEN_WIDTH)-1:0] hcount_out,
    output logic                            valid_out,
    output logic                            last_out,
    output logic                            busy_out
);
    localparam int HW = $clog2(SCREEN_WIDTH);
    localparam logic signed [23:0] CAM0 = -24'sd65536;
    localparam logic signed [23:0] STEP = 24'(131072 / SCREEN_WIDTH);
`ifdef RAY_DIR_ROUND_EN
    localparam logic signed [31:0] RND = 32'sd128;
`else
    localparam logic signed [31:0] RND = 32'sd0;
`endif

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [15:0] w_dir_x, w_dir_y, w_plane_x, w_plane_y;
    logic [15:0] p_pos_x, p_pos_y, p_dir_x, p_dir_y, p_plane_x, p_plane_y;
    logic        pend;
    logic signed [23:0] cam_acc;

    logic xfer, last_xfer, start, adv;
    logic [15:0] src_pos_x, src_pos_y, src_dir_x, src_dir_y;
    logic signed [15:0] src_plane_x, src_plane_y, cam_x;
    logic signed [23:0] cam_src;
    logic signed [31:0] prod_x, prod_y;
    logic [15:0] ray_x, ray_y;
    logic [HW-1:0] next_h;

    always_comb begin
        xfer        = valid_out && ready_in;
        last_xfer   = state == RUN && xfer && last_out;
        start       = (state == IDLE && valid_in) || (last_xfer && (pend || valid_in));
        adv         = state == RUN && !last_out && (!valid_out || ready_in);
        // a new frame takes the freshest pose: the live pulse beats the pending buffer
        src_pos_x   = valid_in ? posX : p_pos_x;
        src_pos_y   = valid_in ? posY : p_pos_y;
        src_dir_x   = start ? (valid_in ? dirX : p_dir_x) : w_dir_x;
        src_dir_y   = start ? (valid_in ? dirY : p_dir_y) : w_dir_y;
        src_plane_x = start ? (valid_in ? planeX : p_plane_x) : w_plane_x;
        src_plane_y = start ? (valid_in ? planeY : p_plane_y) : w_plane_y;
        cam_src     = start ? CAM0 : cam_acc;
        cam_x       = cam_src[23:8];
        prod_x      = src_plane_x * cam_x + RND;
        prod_y      = src_plane_y * cam_x + RND;
        ray_x       = src_dir_x + 16'(prod_x >>> 8);
        ray_y       = src_dir_y + 16'(prod_y >>> 8);
        next_h      = start ? '0 : hcount_out + HW'(1);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            busy_out   <= 1'b0;
            hcount_out <= '0;
            rayDirX    <= '0;
            rayDirY    <= '0;
            posX_out   <= '0;
            posY_out   <= '0;
            pend       <= 1'b0;
            cam_acc    <= '0;
            w_dir_x    <= '0;
            w_dir_y    <= '0;
            w_plane_x  <= '0;
            w_plane_y  <= '0;
            p_pos_x    <= '0;
            p_pos_y    <= '0;
            p_dir_x    <= '0;
            p_dir_y    <= '0;
            p_plane_x  <= '0;
            p_plane_y  <= '0;
        end else begin
            if (valid_in && state == RUN && !start) begin
                pend      <= 1'b1;
                p_pos_x   <= posX;
                p_pos_y   <= posY;
                p_dir_x   <= dirX;
                p_dir_y   <= dirY;
                p_plane_x <= planeX;
                p_plane_y <= planeY;
            end else if (start) begin
                pend <= 1'b0;
            end
            if (start) begin
                state     <= RUN;
                posX_out  <= src_pos_x;
                posY_out  <= src_pos_y;
                w_dir_x   <= src_dir_x;
                w_dir_y   <= src_dir_y;
                w_plane_x <= src_plane_x;
                w_plane_y <= src_plane_y;
            end else if (last_xfer) begin
                state <= IDLE;
            end
            if (start || adv) begin
                valid_out  <= 1'b1;
                rayDirX    <= ray_x;
                rayDirY    <= ray_y;
                hcount_out <= next_h;
                last_out   <= next_h == HW'(SCREEN_WIDTH - 1);
                cam_acc    <= cam_src + STEP;
            end else if (xfer) begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
            busy_out <= start || (state == RUN && !last_xfer);
        end
    end
endmodule

// File: tb/tb_ray_dir_gen.sv
// tb_ray_dir_gen: randomized self-checking bench for ray_dir_gen against a per-column arithmetic model.
module tb_ray_dir_gen;
    localparam int W = 320;
    localparam int HW = $clog2(W);
    localparam int STEP_REF = 131072 / W;

    logic pixel_clk_in = 1'b0;
    logic rst_in = 1'b0, valid_in = 1'b0, ready_in = 1'b0;
    logic [15:0] posX = '0, posY = '0, dirX = '0, dirY = '0, planeX = '0, planeY = '0;
    logic [15:0] rayDirX, rayDirY, posX_out, posY_out;
    logic [HW-1:0] hcount_out;
    logic valid_out, last_out, busy_out;
    int checks = 0, failures = 0;

    always #5 pixel_clk_in = ~pixel_clk_in;

    ray_dir_gen #(.SCREEN_WIDTH(W)) dut (
        .pixel_clk_in(pixel_clk_in), .rst_in(rst_in),
        .posX(posX), .posY(posY), .dirX(dirX), .dirY(dirY), .planeX(planeX), .planeY(planeY),
        .valid_in(valid_in), .ready_in(ready_in),
        .rayDirX(rayDirX), .rayDirY(rayDirY), .posX_out(posX_out), .posY_out(posY_out),
        .hcount_out(hcount_out), .valid_out(valid_out), .last_out(last_out), .busy_out(busy_out)
    );

    // ray component for a column: dir + floor(plane * cameraX / 256), cameraX = floor(cam / 256)
    function automatic logic [15:0] ref_ray(input logic [15:0] d, input logic [15:0] p, input int col);
        int camx, prod;
        camx = (-65536 + col * STEP_REF) >>> 8;
        prod = int'($signed(p)) * camx;
`ifdef RAY_DIR_ROUND_EN
        prod = prod + 128;
`endif
        return 16'(int'($signed(d)) + (prod >>> 8));
    endfunction

    task automatic drive_pose(input logic [15:0] px, py, dx, dy, plx, ply);
        posX = px; posY = py; dirX = dx; dirY = dy; planeX = plx; planeY = ply;
    endtask

    task automatic scramble();
        drive_pose(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic pulse(input logic [15:0] px, py, dx, dy, plx, ply);
        drive_pose(px, py, dx, dy, plx, ply);
        valid_in = 1'b1;
        @(negedge pixel_clk_in);
        valid_in = 1'b0;
        scramble();
    endtask

    task automatic test_reset();
        rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        repeat (3) @(negedge pixel_clk_in);
        checks++;
        if ({valid_out, last_out, busy_out, hcount_out, rayDirX, rayDirY, posX_out, posY_out} !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%b l=%b b=%b h=%0d rx=%h ry=%h px=%h py=%h want all zero",
                     valid_out, last_out, busy_out, hcount_out, rayDirX, rayDirY, posX_out, posY_out);
        end
        rst_in = 1'b1;
        repeat (2) @(negedge pixel_clk_in);
        checks++;
        if ({valid_out, busy_out} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset got v=%b b=%b want 0 0", valid_out, busy_out);
        end
    endtask

    task automatic test_basic_frame();
        logic [15:0] px = 16'($urandom), py = 16'($urandom);
        logic [HW+33:0] exp;
        ready_in = 1'b1;
        pulse(px, py, 16'h0000, 16'h0100, 16'h0000, 16'h00A9);
        checks++;
        if ({busy_out, posX_out, posY_out} !== {1'b1, px, py}) begin
            failures++;
            $display("FAIL basic_pose got b=%b px=%h py=%h want 1 %h %h", busy_out, posX_out, posY_out, px, py);
        end
        for (int c = 0; c < W; c++) begin
            exp = {1'b1, HW'(c), ref_ray(16'h0000, 16'h0000, c), ref_ray(16'h0100, 16'h00A9, c), c == W - 1};
            checks++;
            if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                failures++;
                $display("FAIL basic_col%0d got %h want %h", c, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
            end
            if (c == 0 || c == 160 || c == W - 1) begin
                checks++;
                if ({rayDirX, rayDirY, last_out} !== {16'h0000, c == 0 ? 16'h0057 : c == 160 ? 16'h00FF : 16'h01A7, c == W - 1}) begin
                    failures++;
                    $display("FAIL basic_const_col%0d got rx=%h ry=%h l=%b", c, rayDirX, rayDirY, last_out);
                end
            end
            @(negedge pixel_clk_in);
        end
        checks++;
        if ({valid_out, busy_out} !== 2'b00) begin
            failures++;
            $display("FAIL basic_end got v=%b b=%b want 0 0", valid_out, busy_out);
        end
    endtask

    task automatic test_stall();
        logic [15:0] dx = 16'($urandom), dy = 16'($urandom), plx = 16'($urandom), ply = 16'($urandom);
        logic [HW+33:0] exp;
        ready_in = 1'b1;
        pulse(16'($urandom), 16'($urandom), dx, dy, plx, ply);
        for (int c = 0; c < W; c++) begin
            if (c == 10) begin
                ready_in = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    exp = {1'b1, HW'(10), ref_ray(dx, plx, 10), ref_ray(dy, ply, 10), 1'b0};
                    checks++;
                    if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                        failures++;
                        $display("FAIL stall_hold%0d got %h want %h", k, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
                    end
                    @(negedge pixel_clk_in);
                end
                ready_in = 1'b1;
            end
            exp = {1'b1, HW'(c), ref_ray(dx, plx, c), ref_ray(dy, ply, c), c == W - 1};
            checks++;
            if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                failures++;
                $display("FAIL stall_col%0d got %h want %h", c, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
            end
            @(negedge pixel_clk_in);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL stall_end got v=%b want 0", valid_out);
        end
    endtask

    task automatic test_pending();
        logic [15:0] adx = 16'($urandom), ady = 16'($urandom), aplx = 16'($urandom), aply = 16'($urandom);
        logic [15:0] cpx = 16'($urandom), cpy = 16'($urandom), cdx = 16'($urandom), cplx = 16'($urandom), cply = 16'($urandom);
        logic [HW+33:0] exp;
        ready_in = 1'b1;
        pulse(16'($urandom), 16'($urandom), adx, ady, aplx, aply);
        for (int c = 0; c < W; c++) begin
            exp = {1'b1, HW'(c), ref_ray(adx, aplx, c), ref_ray(ady, aply, c), c == W - 1};
            checks++;
            if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                failures++;
                $display("FAIL pend_a_col%0d got %h want %h", c, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
            end
            valid_in = c == 50 || c == 150;
            if (c == 50) drive_pose(16'($urandom), 16'($urandom), 16'($urandom), 16'h0080, 16'($urandom), 16'($urandom));
            else if (c == 150) drive_pose(cpx, cpy, cdx, 16'h0040, cplx, cply);
            else scramble();
            @(negedge pixel_clk_in);
        end
        valid_in = 1'b0;
        checks++;
        if ({valid_out, hcount_out, rayDirY, posX_out, posY_out} !== {1'b1, HW'(0), ref_ray(16'h0040, cply, 0), cpx, cpy}) begin
            failures++;
            $display("FAIL pend_next_start got v=%b h=%0d ry=%h px=%h py=%h want 1 0 %h %h %h",
                     valid_out, hcount_out, rayDirY, posX_out, posY_out, ref_ray(16'h0040, cply, 0), cpx, cpy);
        end
        for (int c = 0; c < W; c++) begin
            exp = {1'b1, HW'(c), ref_ray(cdx, cplx, c), ref_ray(16'h0040, cply, c), c == W - 1};
            checks++;
            if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                failures++;
                $display("FAIL pend_c_col%0d got %h want %h", c, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
            end
            @(negedge pixel_clk_in);
        end
        checks++;
        if ({valid_out, busy_out} !== 2'b00) begin
            failures++;
            $display("FAIL pend_end got v=%b b=%b want 0 0", valid_out, busy_out);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] dx = 16'($urandom), dy = 16'($urandom), plx = 16'($urandom), ply = 16'($urandom);
        logic [HW+33:0] exp;
        ready_in = 1'b1;
        pulse(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        repeat (100) @(negedge pixel_clk_in);
        checks++;
        if (hcount_out !== HW'(100)) begin
            failures++;
            $display("FAIL rst_mid_reach got h=%0d want 100", hcount_out);
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if ({valid_out, busy_out, last_out, hcount_out} !== '0) begin
            failures++;
            $display("FAIL rst_mid_clear got v=%b b=%b l=%b h=%0d want all zero", valid_out, busy_out, last_out, hcount_out);
        end
        @(negedge pixel_clk_in);
        rst_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge pixel_clk_in);
            checks++;
            if ({valid_out, busy_out} !== 2'b00) begin
                failures++;
                $display("FAIL rst_mid_quiet%0d got v=%b b=%b want 0 0", k, valid_out, busy_out);
            end
        end
        pulse(16'($urandom), 16'($urandom), dx, dy, plx, ply);
        for (int c = 0; c < W; c++) begin
            exp = {1'b1, HW'(c), ref_ray(dx, plx, c), ref_ray(dy, ply, c), c == W - 1};
            checks++;
            if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                failures++;
                $display("FAIL rst_new_col%0d got %h want %h", c, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
            end
            @(negedge pixel_clk_in);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] adx = 16'($urandom), ady = 16'($urandom), aplx = 16'($urandom), aply = 16'($urandom);
        logic [15:0] bdx = 16'($urandom), bdy = 16'($urandom), bplx = 16'($urandom), bply = 16'($urandom);
        logic [HW+33:0] exp;
        ready_in = 1'b1;
        pulse(16'($urandom), 16'($urandom), adx, ady, aplx, aply);
        for (int c = 0; c < W; c++) begin
            exp = {1'b1, HW'(c), ref_ray(adx, aplx, c), ref_ray(ady, aply, c), c == W - 1};
            checks++;
            if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                failures++;
                $display("FAIL b2b_a_col%0d got %h want %h", c, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
            end
            if (c == W - 1) begin
                drive_pose(16'($urandom), 16'($urandom), bdx, bdy, bplx, bply);
                valid_in = 1'b1;
            end
            @(negedge pixel_clk_in);
        end
        valid_in = 1'b0;
        scramble();
        for (int c = 0; c < W; c++) begin
            exp = {1'b1, HW'(c), ref_ray(bdx, bplx, c), ref_ray(bdy, bply, c), c == W - 1};
            checks++;
            if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                failures++;
                $display("FAIL b2b_b_col%0d got %h want %h", c, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
            end
            @(negedge pixel_clk_in);
        end
        checks++;
        if ({valid_out, busy_out} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_end got v=%b b=%b want 0 0", valid_out, busy_out);
        end
    endtask

    task automatic test_random_ready();
        for (int f = 0; f < 4; f++) begin
            logic [15:0] dx = 16'($urandom), dy = 16'($urandom), plx = 16'($urandom), ply = 16'($urandom);
            logic [HW+33:0] exp;
            int col = 0, cyc = 0;
            pulse(16'($urandom), 16'($urandom), dx, dy, plx, ply);
            while (col < W && cyc < 4000) begin
                if (valid_out) begin
                    exp = {1'b1, HW'(col), ref_ray(dx, plx, col), ref_ray(dy, ply, col), col == W - 1};
                    checks++;
                    if ({valid_out, hcount_out, rayDirX, rayDirY, last_out} !== exp) begin
                        failures++;
                        $display("FAIL rand_f%0d_col%0d got %h want %h", f, col, {valid_out, hcount_out, rayDirX, rayDirY, last_out}, exp);
                    end
                end
                ready_in = $urandom_range(0, 99) < 70;
                if (valid_out && ready_in) col++;
                @(negedge pixel_clk_in);
                cyc++;
            end
            checks++;
            if (col != W || valid_out !== 1'b0) begin
                failures++;
                $display("FAIL rand_f%0d_end got cols=%0d v=%b want %0d 0", f, col, valid_out, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_pending();
        test_reset_midframe();
        test_back_to_back();
        test_random_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
